// File: rtl/delay_arbiter.sv
// delay_arbiter: round-robin issue of NUM_REQ requesters into one fixed-latency unit,
// with a parallel tag pipeline that steers each unit result back to its requester.
module delay_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int WIDTH   = 8,
  parameter int LATENCY = 2
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  input  logic [NUM_REQ-1:0]       i_req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] i_req_data,
  output logic [NUM_REQ-1:0]       o_req_ready,
  output logic [WIDTH-1:0]         o_unit_in,
  output logic                     o_unit_in_valid,
  input  logic [WIDTH-1:0]         i_unit_out,
  output logic [NUM_REQ-1:0]       o_resp_valid,
  output logic [WIDTH-1:0]         o_resp_data,
  output logic                     o_busy
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [IW-1:0]              r_ptr;
  logic [IW-1:0]              w_id;
  logic [IW-1:0]              w_nxt;
  logic                       w_found;
  logic                       w_xfer;
  int                         w_d;
  int                         w_best;
  logic [LATENCY:0]           r_tv;
  logic [LATENCY:0][IW-1:0]   r_tid;

  // winner is the valid requester with the smallest wrapped distance from r_ptr
  always_comb begin
    w_id   = '0;
    w_best = NUM_REQ;
    w_d    = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_d = (i >= int'(r_ptr)) ? i - int'(r_ptr) : i + NUM_REQ - int'(r_ptr);
      if (i_req_valid[i] && w_d < w_best) begin
        w_best = w_d;
        w_id   = IW'(i);
      end
    end
  end

  assign w_found     = |i_req_valid;
  assign w_xfer      = w_found & i_reset_n;
  assign o_req_ready = w_found ? NUM_REQ'(1) << w_id : '0;
  assign w_nxt       = (w_id == IW'(NUM_REQ - 1)) ? '0 : w_id + 1'b1;
  assign o_busy      = o_unit_in_valid | (|r_tv) | (|o_resp_valid);

  // tag stage LATENCY lines up with i_unit_out; everything shifts with no stall
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_ptr           <= '0;
      o_unit_in       <= '0;
      o_unit_in_valid <= 1'b0;
      r_tv            <= '0;
      r_tid           <= '0;
      o_resp_valid    <= '0;
      o_resp_data     <= '0;
    end else begin
      if (w_xfer) begin
        r_ptr     <= w_nxt;
        o_unit_in <= i_req_data[w_id*WIDTH +: WIDTH];
      end
      o_unit_in_valid <= w_xfer;
      r_tv            <= {r_tv[LATENCY-1:0], w_xfer};
      r_tid           <= {r_tid[LATENCY-1:0], w_id};
      o_resp_valid    <= r_tv[LATENCY] ? NUM_REQ'(1) << r_tid[LATENCY] : '0;
      o_resp_data     <= i_unit_out;
    end
  end
endmodule

// File: doc/delay_arbiter.md
# delay_arbiter

Round-robin scheduler that shares one fixed-latency datapath unit between NUM_REQ requesters. The unit is typically a `delay` instance or any pipeline with no stall and a constant input-to-output latency. The block accepts at most one request per cycle and issues it to the unit. It carries the requester ID down a parallel tag pipeline and returns the unit's result, strobed to the originating requester. It sits between client logic and the shared pipeline; the unit is instantiated externally and wired to the `unit_*` ports.

## Interface
- NUM_REQ, default 2: number of requesters, ≥ 2.
- WIDTH, default 8: data width of requests and results.
- LATENCY, default 2: cycles from `unit_in_valid` high to the result on `unit_out`, ≥ 1. A `delay` with DELAY_CYCLES = LATENCY-1 matches this.
- clk  input  1  clock; all logic on posedge.
- reset_n  input  1  reset; synchronous, active-low.
- req_valid  input  NUM_REQ  per-requester request.
- req_data  input  NUM_REQ*WIDTH  flattened; requester i occupies bits [i*WIDTH +: WIDTH].
- req_ready  output  NUM_REQ  one-hot grant, combinational from `req_valid` and the RR pointer.
- unit_in  output  WIDTH  registered data to the shared unit.
- unit_in_valid  output  1  registered issue strobe.
- unit_out  input  WIDTH  unit result, valid exactly LATENCY cycles after `unit_in_valid`.
- resp_valid  output  NUM_REQ  registered one-hot result strobe.
- resp_data  output  WIDTH  registered result; meaningful only while any `resp_valid` bit is high.
- busy  output  1  high while any request is issued but its response has not yet been delivered.

## Operation
- Arbitration:
  - Round-robin pointer `ptr`, in range 0..NUM_REQ-1.
  - Grant goes to the first i with `req_valid[i]`, searching from `ptr` upward and wrapping at NUM_REQ.
  - `req_ready[i]` is high only for that i; all bits are 0 when no request is valid.
- Handshake:
  - A request transfers on the edge where `req_valid[i] & req_ready[i]` is high.
  - A requester holds `req_valid` and `req_data` until it is granted; the block does not buffer ungranted requests.
- Pointer update:
  - On a transfer from i, `ptr` becomes (i+1) mod NUM_REQ.
  - With no transfer, `ptr` holds.
- Issue: on a transfer, register `unit_in` = `req_data[i]` and `unit_in_valid` = 1. Otherwise `unit_in_valid` = 0 and `unit_in` holds its last value.
- Tag pipeline:
  - LATENCY+1 stages, each holding {valid, id}.
  - Stage 0 loads {transfer, i}; every other stage shifts each cycle unconditionally.
  - The last stage aligns with `unit_out`.
- Response:
  - Each cycle, register `resp_data` = `unit_out`.
  - Set `resp_valid` = one-hot(last-stage id) when the last stage is valid, else 0.
- busy: OR of `unit_in_valid`, every tag-stage valid bit, and `|resp_valid`.
- Reset (reset_n = 0 at an edge):
  - `ptr` = 0; `unit_in_valid` = 0; `unit_in` = 0.
  - All tag stages invalid; `resp_valid` = 0; `resp_data` = 0; `busy` = 0.
  - `req_ready` follows `req_valid` normally but transfers are ignored while reset_n = 0.
  - Reset mid-operation drops every in-flight response. Unit results that arrive after reset are never strobed.

## Timing
- Request accepted at edge T:
  - `unit_in_valid` is high during cycle T+1 (after edge T).
  - `unit_out` is valid during cycle T+1+LATENCY.
  - `resp_valid` is high during cycle T+2+LATENCY.
  - Total request-to-response latency is LATENCY+2 edges.
- Throughput is one request per cycle; back-to-back grants produce back-to-back responses in grant order.
- Simultaneous requests: exactly one is granted per cycle. A continuously asserted requester waits at most NUM_REQ-1 cycles.
- A single requester asserting every cycle is granted every cycle; `ptr` wraps past it each time.
- Wrap-around: `ptr` = NUM_REQ-1 with a grant to NUM_REQ-1 gives `ptr` = 0.
- `req_ready` may change within a cycle as `req_valid` changes. This is a combinational path from `req_valid` to `req_ready`.

## Test plan
Configuration unless noted: NUM_REQ=2, WIDTH=8, LATENCY=2; unit = `delay`, DELAY_CYCLES=1.
- Reset values: hold reset_n=0 for 2 cycles with `req_valid`=2'b11 → `unit_in_valid`=0, `resp_valid`=0, `busy`=0. After release, the first grant is to requester 0.
- Single request: requester 1 sends 8'hA5 once at edge T → `unit_in`=8'hA5 with valid at T+1; `resp_valid`=2'b10 and `resp_data`=8'hA5 at T+4 only; `busy` low at T+5.
- Contention: both requesters assert for 4 cycles with data 8'h10+n and 8'h20+n → grants alternate 0,1,0,1; responses alternate `resp_valid` 01,10,01,10 with matching data on consecutive cycles.
- Fairness/wrap: NUM_REQ=3, all requesters continuously valid for 6 cycles → grant sequence 0,1,2,0,1,2.
- Reset mid-flight: issue 8'h33 and 8'h44 on consecutive cycles, then assert reset_n=0 for one cycle right after → no `resp_valid` is ever asserted for either, and `busy`=0 after the reset edge.
- Sparse traffic: requester 0 valid every third cycle → each response appears exactly 4 cycles after its grant, and `ptr` alternates correctly between grants.
